// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of the data-memory load/store unit.
// master = core (issues requests), slave = LSU (answers them).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit between the core and a 1 KiB data RAM with
// a registered read port; checks range/alignment and sign/zero-extends loads.
module dmem_lsu #(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
    parameter int          DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    dmem_lsu_if.slave   bus,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_p1, uns_p1;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] offset_p0;
    logic [2:0]  nbytes_p0;
    logic [32:0] end_p0;
    logic        legal_p0;
    logic        accept_p0;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[7:0];
        h = word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, word[7:0]}  : 32'(b);
            2'b01:   r = uns ? {16'd0, word[15:0]} : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    // Stage p0: decode of the offered request (offset wraps modulo 2^32)
    always_comb begin
        offset_p0 = bus.req_addr - DMEM_BASE;
        case (bus.req_size)
            2'b00:   nbytes_p0 = 3'd1;
            2'b01:   nbytes_p0 = 3'd2;
            default: nbytes_p0 = 3'd4;
        endcase
        end_p0   = {1'b0, offset_p0} + {30'd0, nbytes_p0};
        legal_p0 = (bus.req_addr >= DMEM_BASE)
                && (end_p0 <= 33'(DMEM_BYTES))
                && (bus.req_size != 2'b11)
                && !((bus.req_size == 2'b01) && offset_p0[0])
                && !((bus.req_size == 2'b10) && (offset_p0[1:0] != 2'b00));
        accept_p0 = bus.req_valid && (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_p0) state_nxt = legal_p0 ? ACCESS : RESP;
            ACCESS:  state_nxt = we_p1 ? RESP : DATA;
            DATA:    state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
    end

    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Stage p1: RAM port and response registers; mem_we is a one-cycle pulse covering ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_size     <= 2'b00;
            mem_addr     <= 10'd0;
            mem_wdata    <= 32'd0;
            we_p1        <= 1'b0;
            uns_p1       <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            mem_we <= accept_p0 && legal_p0 && bus.req_we;
            case (state)
                IDLE: if (accept_p0) begin
                    we_p1        <= bus.req_we;
                    uns_p1       <= bus.req_unsigned;
                    resp_err_q   <= !legal_p0;
                    resp_rdata_q <= 32'd0;
                    if (legal_p0) begin
                        mem_addr  <= offset_p0[9:0];
                        mem_size  <= bus.req_size;
                        mem_wdata <= bus.req_wdata;
                    end
                end
                DATA:    resp_rdata_q <= extend_load(mem_rdata, mem_size, uns_p1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized + directed scoreboard bench for dmem_lsu with a byte-array RAM
// behind it and a byte-level reference model of the addressing/extension rules.
module tb_dmem_lsu;

    localparam longint BASE  = 64'h1000_0000;
    localparam int     BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_lsu_if bus();

    dmem_lsu #(.DMEM_BASE(32'h1000_0000), .DMEM_BYTES(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_size (mem_size),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          hs;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ram[BYTES];
    logic [7:0]  ref_mem[BYTES];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_we = 0;
    int          we_cycles = 0;
    int          resp_hs_cyc = -1;
    bit          bp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM harness: byte-addressed, little-endian, registered read of the word at mem_addr
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata[7:0];
            if (mem_size != 2'b00) ram[(int'(mem_addr) + 1) % BYTES] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                ram[(int'(mem_addr) + 2) % BYTES] <= mem_wdata[23:16];
                ram[(int'(mem_addr) + 3) % BYTES] <= mem_wdata[31:24];
            end
        end
        mem_rdata <= {ram[(int'(mem_addr) + 3) % BYTES], ram[(int'(mem_addr) + 2) % BYTES],
                      ram[(int'(mem_addr) + 1) % BYTES], ram[mem_addr]};
    end

    always @(negedge clk) if (mem_we) we_cycles++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: legality from address arithmetic, byte-array memory, numeric extension
    function automatic exp_t ref_model(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wd);
        exp_t   e;
        longint a, off, v;
        int     nb;
        a  = {32'd0, addr};
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e.rdata = 32'd0;
        e.hs    = 0;
        if (a < BASE || sz == 2'b11) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        off = a - BASE;
        if (off + nb > BYTES || (off % nb) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        e.err = 1'b0;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
            e.lat = 2;
            exp_we++;
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[int'(off) + i]) << (8 * i));
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            e.rdata = v[31:0];
            e.lat   = 3;
        end
        return e;
    endfunction

    // Offer a request, wait (bounded) for the handshake, push the expected response
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output int hs);
        exp_t e;
        int   n;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        hs = -1;
        n  = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            check("req_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        hs   = cyc;
        e    = ref_model(we, sz, uns, addr, wd);
        e.hs = hs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Monitor: latency on rise, stability while stalled, data on handshake
    exp_t        cur;
    bit          prev_v = 0;
    logic [31:0] hold_rd;
    logic        hold_err;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (bus.resp_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                        cur.rdata = 32'd0; cur.err = 1'b0; cur.lat = 0; cur.hs = cyc;
                    end else begin
                        cur = exp_q[0];
                        check("resp_latency", 32'(cyc - cur.hs), 32'(cur.lat));
                    end
                    hold_rd  = bus.resp_rdata;
                    hold_err = bus.resp_err;
                end else begin
                    check("stall_rdata", bus.resp_rdata, hold_rd);
                    check("stall_err", {31'd0, bus.resp_err}, {31'd0, hold_err});
                end
                if (bus.resp_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    check("resp_rdata", bus.resp_rdata, cur.rdata);
                    check("resp_err", {31'd0, bus.resp_err}, {31'd0, cur.err});
                    resp_hs_cyc = cyc;
                end
            end
            prev_v = bus.resp_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int hs, hs2, n, diff, old_word;
        logic [1:0] sz;
        logic [31:0] a;

        for (int i = 0; i < BYTES; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_size", {30'd0, mem_size}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Store word, then cycle-level view of the RAM port
        issue(1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, hs);
        check("sw_mem_we", {31'd0, mem_we}, 32'd1);
        check("sw_mem_size", {30'd0, mem_size}, 32'd2);
        check("sw_mem_addr", {22'd0, mem_addr}, 32'h010);
        check("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("sw_we_pulse", {31'd0, mem_we}, 32'd0);

        issue(1'b0, 2'b00, 1'b0, 32'h1000_0013, 32'd0, hs);
        issue(1'b0, 2'b00, 1'b1, 32'h1000_0013, 32'd0, hs);
        issue(1'b0, 2'b01, 1'b0, 32'h1000_0012, 32'd0, hs);
        issue(1'b0, 2'b01, 1'b1, 32'h1000_0012, 32'd0, hs);
        issue(1'b0, 2'b10, 1'b0, 32'h1000_0010, 32'd0, hs);

        issue(1'b0, 2'b10, 1'b0, 32'h1000_0012, 32'd0, hs);
        issue(1'b0, 2'b01, 1'b0, 32'h1000_0011, 32'd0, hs);
        issue(1'b1, 2'b11, 1'b0, 32'h1000_0020, 32'h1234_5678, hs);
        issue(1'b1, 2'b10, 1'b0, 32'h1000_03FE, 32'hCAFE_F00D, hs);
        issue(1'b1, 2'b00, 1'b0, 32'h1000_03FF, 32'h0000_00A5, hs);
        check("sb_top_mem_addr", {22'd0, mem_addr}, 32'h3FF);
        check("sb_top_mem_we", {31'd0, mem_we}, 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h0FFF_FFFC, 32'd0, hs);
        issue(1'b0, 2'b10, 1'b0, 32'h1000_0400, 32'd0, hs);

        // Backpressure: response held while a second request is offered
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        issue(1'b0, 2'b01, 1'b0, 32'h1000_03FE, 32'd0, hs);
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("bp_resp_seen", {31'd0, bus.resp_valid}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h1000_0010;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            @(posedge clk); #1;
        end
        fork
            begin @(posedge clk); #1; bus.resp_ready = 1'b1; end
            issue(1'b0, 2'b10, 1'b0, 32'h1000_0010, 32'd0, hs2);
        join
        check("bp_accept_cycle", 32'(hs2), 32'(resp_hs_cyc + 1));

        // Randomized traffic with random response backpressure
        bp_mode = 1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'h1000_0000 - $urandom_range(1, 8);
                2:       a = 32'h1000_0000 + 32'd1016 + $urandom_range(0, 12);
                default: a = 32'h1000_0000 + $urandom_range(0, 1023);
            endcase
            n  = $urandom_range(0, 9);
            sz = (n < 3) ? 2'b00 : (n < 6) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, hs);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bp_mode = 0;
        bus.resp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk); #1;

        // Reset during ACCESS; rewrite the current word so memory is identical whether or not it lands
        old_word = int'({ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]});
        issue(1'b1, 2'b10, 1'b0, 32'h1000_0020, 32'(old_word), hs);
        check("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we_drop", {31'd0, mem_we}, 32'd0);
        check("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        exp_q.delete();
        exp_we--;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end

        check("we_pulse_total", 32'(we_cycles), 32'(exp_we));
        diff = 0;
        for (int i = 0; i < BYTES; i++) if (ram[i] !== ref_mem[i]) diff++;
        check("ram_contents", 32'(diff), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
